// File: rtl/cpu_bus_pkg.sv
// Shared types and defaults for the core's memory-port arbiter.
// ARB_RR_EN (optional macro) selects round-robin instead of fixed LSU priority.
package cpu_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IFU = 2'd1,
    BUSY_LSU = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way picker; grant is one-hot, bit 0 = IFU, bit 1 = LSU.
// With ARB_RR_EN defined, ties go to the requester not granted last.
module arb_pick2
  import cpu_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifndef ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
`ifdef ARB_RR_EN
      grant = (last_grant == OWN_IFU) ? 2'b10 : 2'b01;
`else
      grant = 2'b10;
`endif
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between fetch (IFU) and load/store (LSU),
// one transaction outstanding. ARB_RR_EN enables round-robin tie breaking.
module mem_port_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  input  logic                ifu_flush,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wmask,
  input  logic                bus_resp_valid,
  input  logic [DATA_W-1:0]   bus_rdata
);

  arb_state_e        state_q, state_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] ifu_rdata_q, lsu_rdata_q;
  logic [1:0]        grant;
  logic              last_grant;

`ifdef ARB_RR_EN
  logic last_grant_q, last_grant_d;
  assign last_grant = last_grant_q;
`else
  assign last_grant = OWN_IFU;
`endif

  arb_pick2 u_pick (
    .req        ({lsu_req_valid, ifu_req_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Payload mux follows the winner; the requester holds it stable until accepted.
  assign bus_addr  = grant[1] ? lsu_addr  : ifu_addr;
  assign bus_wdata = grant[1] ? lsu_wdata : '0;
  assign bus_wmask = grant[1] ? lsu_wmask : '0;

  always_comb begin
    state_d        = state_q;
    drop_d         = drop_q;
    bus_req_valid  = 1'b0;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
`ifdef ARB_RR_EN
    last_grant_d   = last_grant_q;
`endif
    if (reset) begin
      unique case (state_q)
        IDLE: begin
          bus_req_valid = |grant;
          if (bus_req_ready && (|grant)) begin
            ifu_req_ready = grant[0];
            lsu_req_ready = grant[1];
            state_d       = grant[1] ? BUSY_LSU : BUSY_IFU;
            drop_d        = 1'b0;
`ifdef ARB_RR_EN
            last_grant_d  = grant[1] ? OWN_LSU : OWN_IFU;
`endif
          end
        end
        BUSY_IFU: begin
          if (bus_resp_valid) begin
            // A flush arriving with the response still kills it.
            ifu_resp_valid = !(drop_q || ifu_flush);
            drop_d         = 1'b0;
            state_d        = IDLE;
          end else if (ifu_flush) begin
            drop_d = 1'b1;
          end
        end
        BUSY_LSU: begin
          if (bus_resp_valid) begin
            lsu_resp_valid = 1'b1;
            state_d        = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ifu_rdata = ifu_resp_valid ? bus_rdata : ifu_rdata_q;
  assign lsu_rdata = lsu_resp_valid ? bus_rdata : lsu_rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      drop_q       <= 1'b0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
`ifdef ARB_RR_EN
      last_grant_q <= OWN_IFU;
`endif
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (ifu_resp_valid) ifu_rdata_q <= bus_rdata;
      if (lsu_resp_valid) lsu_rdata_q <= bus_rdata;
`ifdef ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule
